// File: rtl/key_event_ctrl.sv
// Key event controller: arbitrates debounced keys (lowest index wins), times the held key,
// and hands SHORT/LONG/REPEAT events to the game FSM through a valid/ready holding register.
`timescale 1ns/1ps
module key_event_ctrl #(
    parameter int NKEY       = 4,
    parameter int LONG_MS    = 1000,
    parameter int REPEAT_MS  = 200,
    parameter int ACTIVE_LOW = 1
) (
    input  logic            CLK1K,
    input  logic            RSTN,
    input  logic [NKEY-1:0] KEY_DB,
    input  logic            EVT_READY,
    output logic            EVT_VALID,
    output logic [2:0]      EVT_KEY,
    output logic [1:0]      EVT_TYPE,
    output logic            BUSY,
    output logic            DROP,
    output logic [1:0]      STATE_DBG
);

    // Handshake: an event transfers in every cycle where EVT_VALID=1 and EVT_READY=1;
    // EVT_KEY/EVT_TYPE hold steady while EVT_VALID=1 and EVT_READY=0.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HELD = 2'd1,
        S_RPT  = 2'd2
    } state_t;

    localparam logic [1:0]      T_SHORT  = 2'd0;
    localparam logic [1:0]      T_LONG   = 2'd1;
    localparam logic [1:0]      T_REPEAT = 2'd2;
    localparam logic [NKEY-1:0] REL_LVL  = (ACTIVE_LOW != 0) ? {NKEY{1'b1}} : {NKEY{1'b0}};
    localparam logic [15:0]     LONG_TOP = 16'(LONG_MS - 1);
    localparam logic [15:0]     RPT_TOP  = 16'(REPEAT_MS - 1);

    state_t          state, state_n;
    logic [15:0]     timer, timer_n;
    logic [2:0]      cur, cur_n;
    logic [NKEY-1:0] key_prev;
    logic            armed;
    logic [NKEY-1:0] pressed, pressed_prev, press_edge;
    logic [2:0]      edge_idx;
    logic            cur_held;
    logic            emit;
    logic [1:0]      emit_type;

    assign pressed      = KEY_DB ^ REL_LVL;
    assign pressed_prev = key_prev ^ REL_LVL;
    // Keys already held when reset is released must not look like fresh presses.
    assign press_edge   = armed ? (pressed & ~pressed_prev) : '0;

    always_ff @(posedge CLK1K or negedge RSTN) begin
        if (!RSTN) begin
            key_prev <= REL_LVL;
            armed    <= 1'b0;
        end else begin
            key_prev <= KEY_DB;
            armed    <= 1'b1;
        end
    end

    always_comb begin
        edge_idx = 3'd0;
        for (int i = NKEY - 1; i >= 0; i--) begin
            if (press_edge[i]) edge_idx = 3'(i);
        end
    end

    // Release is judged on the registered level, one cycle behind KEY_DB.
    always_comb begin
        cur_held = 1'b0;
        for (int i = 0; i < NKEY; i++) begin
            if (3'(i) == cur) cur_held = pressed_prev[i];
        end
    end

    always_ff @(posedge CLK1K or negedge RSTN) begin
        if (!RSTN) begin
            state <= S_IDLE;
            timer <= 16'd0;
            cur   <= 3'd0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            cur   <= cur_n;
        end
    end

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        cur_n     = cur;
        emit      = 1'b0;
        emit_type = T_SHORT;
        case (state)
            S_IDLE: begin
                if (|press_edge) begin
                    cur_n   = edge_idx;
                    timer_n = 16'd0;
                    state_n = S_HELD;
                end
            end
            S_HELD: begin
                if (!cur_held) begin
                    emit      = 1'b1;
                    emit_type = T_SHORT;
                    timer_n   = 16'd0;
                    state_n   = S_IDLE;
                end else if (timer == LONG_TOP) begin
                    emit      = 1'b1;
                    emit_type = T_LONG;
                    timer_n   = 16'd0;
                    state_n   = S_RPT;
                end else begin
                    timer_n = timer + 16'd1;
                end
            end
            S_RPT: begin
                if (!cur_held) begin
                    timer_n = 16'd0;
                    state_n = S_IDLE;
                end else if (timer == RPT_TOP) begin
                    emit      = 1'b1;
                    emit_type = T_REPEAT;
                    timer_n   = 16'd0;
                end else begin
                    timer_n = timer + 16'd1;
                end
            end
            default: begin
                timer_n = 16'd0;
                state_n = S_IDLE;
            end
        endcase
    end

    // Holding register: a new event may replace one being accepted in the same cycle.
    always_ff @(posedge CLK1K or negedge RSTN) begin
        if (!RSTN) begin
            EVT_VALID <= 1'b0;
            EVT_KEY   <= 3'd0;
            EVT_TYPE  <= T_SHORT;
            DROP      <= 1'b0;
        end else begin
            DROP <= emit && EVT_VALID && !EVT_READY;
            if (emit && (!EVT_VALID || EVT_READY)) begin
                EVT_VALID <= 1'b1;
                EVT_KEY   <= cur;
                EVT_TYPE  <= emit_type;
            end else if (EVT_VALID && EVT_READY) begin
                EVT_VALID <= 1'b0;
            end
        end
    end

    assign BUSY      = (state != S_IDLE);
    assign STATE_DBG = state;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: directed scenarios plus random key/ready traffic,
// checked every cycle against a hold-time model and an expected-event queue.
`timescale 1ns/1ps
module tb_key_event_ctrl;

    localparam int LONG_MS   = 1000;
    localparam int REPEAT_MS = 200;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] key_db = 4'hF;
    logic       ready = 1'b1;
    logic       evt_valid, busy, drop;
    logic [2:0] evt_key;
    logic [1:0] evt_type, state_dbg;

    key_event_ctrl #(.NKEY(4), .LONG_MS(LONG_MS), .REPEAT_MS(REPEAT_MS), .ACTIVE_LOW(1)) dut (
        .CLK1K(clk), .RSTN(rstn), .KEY_DB(key_db), .EVT_READY(ready),
        .EVT_VALID(evt_valid), .EVT_KEY(evt_key), .EVT_TYPE(evt_type),
        .BUSY(busy), .DROP(drop), .STATE_DBG(state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_acc    = 0;
    int n_drop   = 0;
    bit rnd_ready = 1'b0;

    // Reference model: which key is being served and how long it has been served.
    bit         m_busy;
    int         m_cur, m_age;
    logic [3:0] m_pprev;
    bit         e_valid, e_drop;
    logic [2:0] e_key;
    logic [1:0] e_type;
    logic [4:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_cur   = 0;
        m_age   = 0;
        e_valid = 1'b0;
        e_drop  = 1'b0;
        e_key   = 3'd0;
        e_type  = 2'd0;
        m_pprev = ~key_db;
        exp_q.delete();
    endtask

    task automatic step();
        logic [3:0] p, e;
        bit         emit;
        logic [1:0] etype;
        logic [4:0] front;
        p     = ~key_db;
        emit  = 1'b0;
        etype = 2'd0;
        if (evt_valid && ready) begin
            n_acc++;
            if (exp_q.size() == 0) check("sb_unexpected", {evt_key, evt_type}, 5'h1F);
            else begin
                front = exp_q.pop_front();
                check("sb_evt", {evt_key, evt_type}, front);
            end
        end
        if (!m_busy) begin
            e = p & ~m_pprev;
            if (e != 4'd0) begin
                for (int i = 3; i >= 0; i--) if (e[i]) m_cur = i;
                m_busy = 1'b1;
                m_age  = 0;
            end
        end else begin
            m_age++;
            if (!m_pprev[m_cur]) begin
                if (m_age <= LONG_MS) begin emit = 1'b1; etype = 2'd0; end
                m_busy = 1'b0;
            end else if (m_age == LONG_MS) begin
                emit = 1'b1; etype = 2'd1;
            end else if (m_age > LONG_MS && (m_age - LONG_MS) % REPEAT_MS == 0) begin
                emit = 1'b1; etype = 2'd2;
            end
        end
        e_drop = emit && e_valid && !ready;
        if (emit && (!e_valid || ready)) begin
            e_valid = 1'b1;
            e_key   = 3'(m_cur);
            e_type  = etype;
            exp_q.push_back({e_key, e_type});
        end else if (e_valid && ready) begin
            e_valid = 1'b0;
        end
        m_pprev = p;
        @(posedge clk);
        #1;
        if (drop) n_drop++;
        check("cyc", {busy, evt_valid, drop, (state_dbg != 2'd0)}, {m_busy, e_valid, e_drop, m_busy});
        if (e_valid) check("hold", {evt_key, evt_type}, {e_key, e_type});
        if (rnd_ready) ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #2;
        check("rst_out", {evt_valid, evt_key, evt_type, busy, drop}, 8'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        #1;
    endtask

    int a0, d0;

    initial begin
        model_reset();
        do_reset();
        hold(3);

        // Short press on key 2.
        a0 = n_acc; d0 = n_drop;
        key_db = 4'b1011; hold(10);
        key_db = 4'hF;    hold(6);
        check("short_cnt", n_acc - a0, 1);
        check("short_drop", n_drop - d0, 0);

        // Long hold on key 0: LONG then two REPEATs, nothing on release.
        a0 = n_acc;
        key_db = 4'b1110; hold(1500);
        key_db = 4'hF;    hold(6);
        check("long_cnt", n_acc - a0, 3);

        // Keys 3 and 1 together: key 1 wins, key 3 is discarded.
        a0 = n_acc;
        key_db = 4'b0101; hold(10);
        key_db = 4'hF;    hold(6);
        check("arb_cnt", n_acc - a0, 1);

        // Consumer stalled: second short press is dropped.
        ready = 1'b0; a0 = n_acc; d0 = n_drop;
        key_db = 4'b1101; hold(8);
        key_db = 4'hF;    hold(4);
        key_db = 4'b0111; hold(8);
        key_db = 4'hF;    hold(4);
        check("drop_cnt", n_drop - d0, 1);
        ready = 1'b1; hold(2);
        check("drop_acc", n_acc - a0, 1);

        // Accept and load in the same cycle: no bubble, no drop.
        ready = 1'b0; d0 = n_drop;
        key_db = 4'b1110; hold(5);
        key_db = 4'hF;    hold(4);
        key_db = 4'b1011; hold(5);
        key_db = 4'hF;    step();
        ready = 1'b1;     step();
        check("nobubble_valid", evt_valid, 1);
        check("nobubble_key", evt_key, 2);
        hold(3);
        check("nobubble_drop", n_drop - d0, 0);

        // Reset in the middle of a hold; key stays down across reset.
        a0 = n_acc;
        key_db = 4'b1110; hold(500);
        do_reset();
        hold(50);
        check("rst_noevt", n_acc - a0, 0);
        key_db = 4'hF;    hold(5);
        key_db = 4'b1110; hold(5);
        key_db = 4'hF;    hold(5);
        check("rst_repress", n_acc - a0, 1);

        // Random traffic.
        rnd_ready = 1'b1;
        for (int s = 0; s < 60; s++) begin
            key_db = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) hold($urandom_range(900, 1500));
            else hold($urandom_range(1, 40));
            if ($urandom_range(0, 19) == 0) begin
                do_reset();
                step();
            end
        end
        rnd_ready = 1'b0;
        ready = 1'b1;
        key_db = 4'hF;
        hold(10);
        check("sb_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
